idiv_seq: RTL



---
 rtl/idiv_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/idiv_seq.sv
// rtl/idiv_seq.sv - sequential unsigned restoring divider, one quotient bit per cycle
//
// Ports:
//   Clock       system clock, all state updates on the rising edge
//   Reset       synchronous active-high reset
//   iStart      start request, accepted only in IDLE
//   iDividend   2N-bit unsigned dividend, captured with an accepted start
//   iDivisor    N-bit unsigned divisor, captured with an accepted start
//   oBusy       high while iterating (CALC)
//   oDone       one-cycle pulse qualifying the result outputs
//   oDivByZero  set with oDone when the divisor was zero, held until next start
//   oQuotient   2N-bit quotient (all ones on divide by zero)
//   oRemainder  N-bit remainder (all ones on divide by zero)
module idiv_seq #(
    parameter int N = 4
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           iStart,
    input  logic [2*N-1:0] iDividend,
    input  logic [N-1:0]   iDivisor,
    output logic           oBusy,
    output logic           oDone,
    output logic           oDivByZero,
    output logic [2*N-1:0] oQuotient,
    output logic [N-1:0]   oRemainder
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    // Dividend bits leave at the top while quotient bits enter at the bottom,
    // so after W iterations this register holds the full quotient.
    logic [W-1:0]   shreg;
    logic [N-1:0]   divisor;
    // Running remainder is always < divisor, so N bits are enough to store it.
    logic [N-1:0]   rem;
    logic [CW-1:0]  count;

    // Shifted partial remainder is N+1 bits so the compare never overflows.
    logic [N:0]     partial;
    logic           qbit;
    logic [N-1:0]   next_rem;
    logic           last_iter;

    always_comb begin
        partial   = {rem, shreg[W-1]};
        qbit      = (partial >= {1'b0, divisor});
        // When qbit is set the difference is < divisor, so it fits N bits.
        next_rem  = qbit ? (partial[N-1:0] - divisor) : partial[N-1:0];
        last_iter = (count == CW'(W - 1));
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            shreg      <= '0;
            divisor    <= '0;
            rem        <= '0;
            count      <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oDivByZero <= 1'b0;
            oQuotient  <= '0;
            oRemainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        shreg      <= iDividend;
                        divisor    <= iDivisor;
                        rem        <= '0;
                        count      <= '0;
                        oDivByZero <= 1'b0;
                        if (iDivisor == '0) begin
                            // Skip iterating entirely; report saturated results.
                            oQuotient  <= '1;
                            oRemainder <= '1;
                            oDivByZero <= 1'b1;
                            oDone      <= 1'b1;
                            state      <= DONE;
                        end else begin
                            oBusy <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= next_rem;
                    shreg <= {shreg[W-2:0], qbit};
                    count <= count + CW'(1);
                    if (last_iter) begin
                        oQuotient  <= {shreg[W-2:0], qbit};
                        oRemainder <= next_rem;
                        oBusy      <= 1'b0;
                        oDone      <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    oDone <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    oBusy <= 1'b0;
                    oDone <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
